module_captura: RTL and testbench

MODULE_CAPTURA -- requirements
Module: module_captura

---
 rtl/pkg_teclado.sv | 26 ++
 rtl/module_acum_dec.sv | 70 +++++++
 rtl/module_captura.sv | 136 +++++++++++++
 tb/tb_module_captura.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/pkg_teclado.sv
// ---------------------------------------------------------------------------
// pkg_teclado
// Shared definitions for the keypad operand-capture block: key-code
// constants, operand limits and the capture FSM state type.
// ---------------------------------------------------------------------------
package pkg_teclado;

  localparam logic [3:0] KEY_CONFIRM = 4'hA;
  localparam logic [3:0] KEY_CLEAR   = 4'hB;
  localparam logic [3:0] KEY_DELETE  = 4'hC;

  localparam int OPERAND_MAX = 255;
  localparam int MAX_DIGITS  = 3;

  typedef enum logic [1:0] {
    E_NUM1  = 2'd0,
    E_NUM2  = 2'd1,
    E_LISTO = 2'd2
  } estado_t;

  // Codes 0x0..0x9 are decimal digits.
  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/module_acum_dec.sv
// ---------------------------------------------------------------------------
// module_acum_dec
// One decimal operand accumulator: value register, digit counter and the
// accept/reject decision for a new digit (and, with CAPTURA_BORRAR_EN
// defined, for a delete request).
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   clr           synchronous clear of value and digit count
//   digit_en      a digit key addressed to this operand
//   digit         digit value 0..9
//   del_en        delete request (only with CAPTURA_BORRAR_EN)
//   value         registered operand value
//   has_digits    at least one digit entered
//   reject        combinational: current request is refused this cycle
// ---------------------------------------------------------------------------
module module_acum_dec
  import pkg_teclado::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       digit_en,
  input  logic [3:0] digit,
`ifdef CAPTURA_BORRAR_EN
  input  logic       del_en,
`endif
  output logic [7:0] value,
  output logic       has_digits,
  output logic       reject
);

  logic [1:0]  count;
  logic [11:0] candidate;
  logic        accept;

  // Evaluated at 12 bits so an overflow past 255 is seen before truncation.
  assign candidate  = ({4'd0, value} * 12'd10) + {8'd0, digit};
  assign accept     = digit_en && (count < 2'(MAX_DIGITS))
                      && (candidate <= 12'(OPERAND_MAX));
  assign has_digits = (count != 2'd0);

`ifdef CAPTURA_BORRAR_EN
  assign reject = (digit_en && !accept) || (del_en && (count == 2'd0));
`else
  assign reject = digit_en && !accept;
`endif

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= 8'd0;
      count <= 2'd0;
    end else if (clr) begin
      value <= 8'd0;
      count <= 2'd0;
    end else if (accept) begin
      value <= candidate[7:0];
      count <= count + 2'd1;
    end
`ifdef CAPTURA_BORRAR_EN
    else if (del_en && (count != 2'd0)) begin
      value <= value / 8'd10;
      count <= count - 2'd1;
    end
`endif
  end

endmodule

// File: rtl/module_captura.sv
// ---------------------------------------------------------------------------
// module_captura
// Captures two decimal operands (0..255, up to 3 digits each) from debounced
// keypad events. Confirm moves from operand 1 to operand 2 and then to the
// result phase; clear restarts from any state.
//
// Optional feature: define CAPTURA_BORRAR_EN to enable key 0xC (delete last
// digit). Without it, 0xC is ignored and no divider is built.
//
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   key_valid   one-cycle keypress strobe
//   key_code    key value, sampled only with key_valid
//   num_1/num_2 registered operands
//   listo_1     high while operand 1 is confirmed
//   listo_2     one-cycle pulse when operand 2 is confirmed
//   listo       high while both operands are confirmed
//   err         one-cycle pulse when a key is rejected
// ---------------------------------------------------------------------------
module module_captura
  import pkg_teclado::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [7:0] num_1,
  output logic [7:0] num_2,
  output logic       listo_1,
  output logic       listo_2,
  output logic       listo,
  output logic       err
);

  estado_t state_q, state_d;
  logic    clr, en_1, en_2, confirm_err, listo_2_d, err_d;
  logic    has_1, has_2, rej_1, rej_2;
`ifdef CAPTURA_BORRAR_EN
  logic    del_1, del_2;
`endif

  module_acum_dec u_op1 (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .digit_en   (en_1),
    .digit      (key_code),
`ifdef CAPTURA_BORRAR_EN
    .del_en     (del_1),
`endif
    .value      (num_1),
    .has_digits (has_1),
    .reject     (rej_1)
  );

  module_acum_dec u_op2 (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .digit_en   (en_2),
    .digit      (key_code),
`ifdef CAPTURA_BORRAR_EN
    .del_en     (del_2),
`endif
    .value      (num_2),
    .has_digits (has_2),
    .reject     (rej_2)
  );

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    clr         = 1'b0;
    en_1        = 1'b0;
    en_2        = 1'b0;
    confirm_err = 1'b0;
    listo_2_d   = 1'b0;
`ifdef CAPTURA_BORRAR_EN
    del_1       = 1'b0;
    del_2       = 1'b0;
`endif
    if (key_valid) begin
      if (key_code == KEY_CLEAR) begin
        clr     = 1'b1;
        state_d = E_NUM1;
      end else begin
        unique case (state_q)
          E_NUM1: begin
            if (is_digit(key_code)) en_1 = 1'b1;
            else if (key_code == KEY_CONFIRM) begin
              if (has_1) state_d = E_NUM2;
              else       confirm_err = 1'b1;
            end
`ifdef CAPTURA_BORRAR_EN
            else if (key_code == KEY_DELETE) del_1 = 1'b1;
`endif
          end
          E_NUM2: begin
            if (is_digit(key_code)) en_2 = 1'b1;
            else if (key_code == KEY_CONFIRM) begin
              if (has_2) begin
                state_d   = E_LISTO;
                listo_2_d = 1'b1;
              end else begin
                confirm_err = 1'b1;
              end
            end
`ifdef CAPTURA_BORRAR_EN
            else if (key_code == KEY_DELETE) del_2 = 1'b1;
`endif
          end
          default: ;  // E_LISTO: only clear is acted on
        endcase
      end
    end
    err_d = confirm_err || rej_1 || rej_2;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= E_NUM1;
      listo_2 <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      listo_2 <= listo_2_d;
      err     <= err_d;
    end
  end

  // Level flags are direct decodes of the state register.
  assign listo_1 = (state_q != E_NUM1);
  assign listo   = (state_q == E_LISTO);

endmodule

// File: tb/tb_module_captura.sv
// ---------------------------------------------------------------------------
// tb_module_captura
// Directed self-checking bench for module_captura. Build with
// CAPTURA_BORRAR_EN defined to also exercise the delete key.
// ---------------------------------------------------------------------------
module tb_module_captura;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic [7:0] num_1, num_2;
  logic       listo_1, listo_2, listo, err;

  int n_cmp = 0;
  int n_bad = 0;

  module_captura dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_code  (key_code),
    .num_1     (num_1),
    .num_2     (num_2),
    .listo_1   (listo_1),
    .listo_2   (listo_2),
    .listo     (listo),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Drive one key for one cycle; returns on the negedge after the capturing
  // posedge, where registered outputs and pulses are visible.
  task automatic press(input logic [3:0] k);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = k;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic test_reset;
    #12;
    n_cmp++; if (num_1 !== 8'd0) begin n_bad++; $display("FAIL reset_num_1: got %0d want 0", num_1); end
    n_cmp++; if (num_2 !== 8'd0) begin n_bad++; $display("FAIL reset_num_2: got %0d want 0", num_2); end
    n_cmp++; if ({listo_1, listo_2, listo, err} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_flags: got %b want 0000", {listo_1, listo_2, listo, err}); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_scenario1;
    press(4'h1); press(4'h2); press(4'h3);
    n_cmp++; if (num_1 !== 8'd123) begin n_bad++; $display("FAIL s1_num_1: got %0d want 123", num_1); end
    n_cmp++; if (listo_1 !== 1'b0) begin n_bad++; $display("FAIL s1_listo_1_before: got %b want 0", listo_1); end
    press(4'hA);
    n_cmp++; if (listo_1 !== 1'b1) begin n_bad++; $display("FAIL s1_listo_1: got %b want 1", listo_1); end
    n_cmp++; if (listo !== 1'b0) begin n_bad++; $display("FAIL s1_listo_early: got %b want 0", listo); end
    press(4'h4); press(4'h5);
    n_cmp++; if (num_2 !== 8'd45) begin n_bad++; $display("FAIL s1_num_2: got %0d want 45", num_2); end
    n_cmp++; if (listo_2 !== 1'b0) begin n_bad++; $display("FAIL s1_listo_2_early: got %b want 0", listo_2); end
    press(4'hA);
    n_cmp++; if (listo_2 !== 1'b1) begin n_bad++; $display("FAIL s1_listo_2_pulse: got %b want 1", listo_2); end
    n_cmp++; if (listo !== 1'b1) begin n_bad++; $display("FAIL s1_listo: got %b want 1", listo); end
    @(negedge clk);
    n_cmp++; if (listo_2 !== 1'b0) begin n_bad++; $display("FAIL s1_listo_2_width: got %b want 0", listo_2); end
    n_cmp++; if ({listo_1, listo} !== 2'b11) begin n_bad++; $display("FAIL s1_levels_held: got %b want 11", {listo_1, listo}); end
    n_cmp++; if (num_1 !== 8'd123) begin n_bad++; $display("FAIL s1_num_1_held: got %0d want 123", num_1); end
  endtask

  task automatic test_listo_ignore_and_clear;
    press(4'h7);
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL s5_err_in_listo: got %b want 0", err); end
    n_cmp++; if ({num_1, num_2} !== {8'd123, 8'd45}) begin
      n_bad++; $display("FAIL s5_nums_held: got %0d/%0d want 123/45", num_1, num_2); end
    press(4'hA);
    n_cmp++; if ({listo_2, err, listo} !== 3'b001) begin
      n_bad++; $display("FAIL s5_confirm_in_listo: got %b want 001", {listo_2, err, listo}); end
    press(4'hB);
    n_cmp++; if ({num_1, num_2, listo_1, listo_2, listo, err} !== 20'd0) begin
      n_bad++; $display("FAIL s5_clear: got %0d/%0d flags %b want all 0", num_1, num_2, {listo_1, listo_2, listo, err}); end
    press(4'h9); press(4'hA);
    n_cmp++; if ({num_1, listo_1} !== {8'd9, 1'b1}) begin
      n_bad++; $display("FAIL s5_reentry: got %0d/%b want 9/1", num_1, listo_1); end
  endtask

  task automatic test_overflow;
    press(4'hB); press(4'h2); press(4'h5);
    n_cmp++; if (num_1 !== 8'd25) begin n_bad++; $display("FAIL s2_num_1: got %0d want 25", num_1); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL s2_err_before: got %b want 0", err); end
    press(4'h6);
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL s2_err_pulse: got %b want 1", err); end
    n_cmp++; if (num_1 !== 8'd25) begin n_bad++; $display("FAIL s2_num_1_held: got %0d want 25", num_1); end
    @(negedge clk);
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL s2_err_width: got %b want 0", err); end
    // 255 is the largest accepted value.
    press(4'h5);
    n_cmp++; if ({num_1, err} !== {8'd255, 1'b0}) begin
      n_bad++; $display("FAIL max_255: got %0d err %b want 255 err 0", num_1, err); end
  endtask

  task automatic test_fourth_digit;
    press(4'hB); press(4'h1); press(4'h2); press(4'h3); press(4'h4);
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL s3_err: got %b want 1", err); end
    n_cmp++; if (num_1 !== 8'd123) begin n_bad++; $display("FAIL s3_num_1: got %0d want 123", num_1); end
    // Fourth digit into operand 2 (leading zeros count as digits).
    press(4'hA); press(4'h0); press(4'h0); press(4'h7); press(4'h1);
    n_cmp++; if ({num_2, err} !== {8'd7, 1'b1}) begin
      n_bad++; $display("FAIL op2_fourth: got %0d err %b want 7 err 1", num_2, err); end
  endtask

  task automatic test_empty_confirm;
    press(4'hB); press(4'hA);
    n_cmp++; if ({err, listo_1} !== 2'b10) begin
      n_bad++; $display("FAIL s4_empty_confirm: got %b want 10", {err, listo_1}); end
    press(4'h5); press(4'hA); press(4'hA);
    n_cmp++; if ({err, listo_1, listo, listo_2} !== 4'b1100) begin
      n_bad++; $display("FAIL empty_confirm_op2: got %b want 1100", {err, listo_1, listo, listo_2}); end
  endtask

  task automatic test_ignored_codes;
    press(4'hB); press(4'h4);
    press(4'hD); press(4'hE); press(4'hF);
`ifndef CAPTURA_BORRAR_EN
    press(4'hC);
`endif
    n_cmp++; if ({num_1, err, listo_1} !== {8'd4, 1'b0, 1'b0}) begin
      n_bad++; $display("FAIL ignored_codes: got %0d err %b listo_1 %b want 4 0 0", num_1, err, listo_1); end
    // key_code alone, without key_valid, must do nothing.
    @(negedge clk); key_code = 4'h7;
    @(negedge clk); key_code = 4'hA;
    @(negedge clk); key_code = 4'hB;
    @(negedge clk);
    n_cmp++; if ({num_1, listo_1} !== {8'd4, 1'b0}) begin
      n_bad++; $display("FAIL no_valid: got %0d listo_1 %b want 4 0", num_1, listo_1); end
  endtask

  task automatic test_reset_mid_entry;
    press(4'hB); press(4'h8); press(4'h8);
    n_cmp++; if (num_1 !== 8'd88) begin n_bad++; $display("FAIL s6_num_1_pre: got %0d want 88", num_1); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (num_1 !== 8'd0) begin n_bad++; $display("FAIL s6_async_reset: got %0d want 0", num_1); end
    @(negedge clk);
    // Reset held across an edge with a key present: reset wins.
    key_valid = 1'b1; key_code = 4'h5;
    @(negedge clk);
    rst = 1'b0; key_valid = 1'b0;
    n_cmp++; if ({num_1, err} !== {8'd0, 1'b0}) begin
      n_bad++; $display("FAIL rst_override: got %0d err %b want 0 0", num_1, err); end
    // The discarded partial entry leaves three fresh digit slots.
    press(4'h1); press(4'h2); press(4'h3);
    n_cmp++; if ({num_1, err} !== {8'd123, 1'b0}) begin
      n_bad++; $display("FAIL after_reset_count: got %0d err %b want 123 0", num_1, err); end
  endtask

`ifdef CAPTURA_BORRAR_EN
  task automatic test_delete;
    press(4'hB); press(4'h8); press(4'h8); press(4'hC);
    n_cmp++; if ({num_1, err} !== {8'd8, 1'b0}) begin
      n_bad++; $display("FAIL del_once: got %0d err %b want 8 0", num_1, err); end
    press(4'hC);
    n_cmp++; if (num_1 !== 8'd0) begin n_bad++; $display("FAIL del_twice: got %0d want 0", num_1); end
    press(4'hC);
    n_cmp++; if ({num_1, err} !== {8'd0, 1'b1}) begin
      n_bad++; $display("FAIL del_empty: got %0d err %b want 0 1", num_1, err); end
    press(4'h1); press(4'h2); press(4'hC); press(4'h3); press(4'h4);
    n_cmp++; if ({num_1, err} !== {8'd134, 1'b0}) begin
      n_bad++; $display("FAIL del_recount: got %0d err %b want 134 0", num_1, err); end
    press(4'hA); press(4'h6); press(4'h7); press(4'hC);
    n_cmp++; if ({num_2, num_1} !== {8'd6, 8'd134}) begin
      n_bad++; $display("FAIL del_op2: got %0d/%0d want 6/134", num_2, num_1); end
  endtask
`endif

  initial begin
    test_reset();
    test_scenario1();
    test_listo_ignore_and_clear();
    test_overflow();
    test_fourth_digit();
    test_empty_confirm();
    test_ignored_codes();
    test_reset_mid_entry();
`ifdef CAPTURA_BORRAR_EN
    test_delete();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
